// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache fill path
// and the D-cache fill/writeback path. One transaction at a time moves
// through IDLE -> ISSUE -> (WAIT) -> DONE. The D side wins by default, but
// after STARVE_LIMIT consecutive D grants with an I request waiting, the
// I side is forced through. Read returns that never arrive time out with
// 0xFFFF data and a sticky error flag.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic        i_done,
  output logic [15:0] i_rdata,

  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic        d_done,
  output logic [15:0] d_rdata,

  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_stall,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,

  output logic        busy,
  output logic        err,
  output logic [15:0] i_grant_cnt,
  output logic [15:0] d_grant_cnt
);

  // Counter widths: starve_cnt holds 0..STARVE_LIMIT, to_cnt holds 0..TIMEOUT-1.
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic          own_d;      // 1 = D side owns the in-flight transaction
  logic          lat_wr;
  logic [15:0]   lat_addr;
  logic [15:0]   lat_wdata;
  logic [TW-1:0] to_cnt;
  logic [SW-1:0] starve_cnt;

  logic          req_any;
  logic          pick_i;
  logic          grant_i;
  logic          grant_d;
  logic          timed_out;
  logic [15:0]   wait_data;

  // Arbitration: D by default; I when D is absent or I has been starved long enough.
  assign req_any = i_req | d_req;
  assign pick_i  = ~d_req | (i_req & (starve_cnt == SW'(STARVE_LIMIT)));
  assign grant_i = (state == IDLE) & req_any & pick_i;
  assign grant_d = (state == IDLE) & req_any & ~pick_i;

  // In WAIT, either real data arrives or the timeout substitutes 0xFFFF.
  assign timed_out = (to_cnt == TW'(TIMEOUT - 1));
  assign wait_data = mem_rvalid ? mem_rdata : 16'hFFFF;

  // Backend port is driven only while ISSUE is active, straight from the latched
  // request, so it stays stable across stalls and drops with the async reset.
  assign mem_en    = (state == ISSUE);
  assign mem_wr    = mem_en & lat_wr;
  assign mem_addr  = mem_en ? lat_addr  : 16'h0000;
  assign mem_wdata = mem_en ? lat_wdata : 16'h0000;
  assign busy      = (state != IDLE);

  // Main FSM: latches the winner, sequences the backend, returns data and pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      own_d     <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      to_cnt    <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= 16'h0000;
      d_rdata   <= 16'h0000;
      err       <= 1'b0;
    end else begin
      i_ack  <= 1'b0;
      d_ack  <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;

      // Read data with nothing waiting for it is dropped and flagged.
      if (mem_rvalid && (state != WAIT)) begin
        err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_any) begin
            state <= ISSUE;
            own_d <= ~pick_i;
            if (pick_i) begin
              lat_wr    <= 1'b0;
              lat_addr  <= i_addr;
              lat_wdata <= 16'h0000;
              i_ack     <= 1'b1;
            end else begin
              lat_wr    <= d_wr;
              lat_addr  <= d_addr;
              lat_wdata <= d_wdata;
              d_ack     <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (!mem_stall) begin
            if (lat_wr) begin
              // Only the D side writes; a write completes as soon as it is accepted.
              state   <= DONE;
              d_done  <= 1'b1;
              d_rdata <= 16'h0000;
            end else begin
              state  <= WAIT;
              to_cnt <= '0;
            end
          end
        end

        WAIT: begin
          if (mem_rvalid || timed_out) begin
            state <= DONE;
            if (!mem_rvalid) begin
              err <= 1'b1;
            end
            if (own_d) begin
              d_done  <= 1'b1;
              d_rdata <= wait_data;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= wait_data;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Starvation guard: counts D grants made while an I request was waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Saturating grant counters, stepped by the ack pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_grant_cnt <= 16'h0000;
      d_grant_cnt <= 16'h0000;
    end else begin
      if (i_ack && (i_grant_cnt != 16'hFFFF)) begin
        i_grant_cnt <= i_grant_cnt + 16'd1;
      end
      if (d_ack && (d_grant_cnt != 16'hFFFF)) begin
        d_grant_cnt <= d_grant_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transactions against a
// transaction-level reference (timeline arithmetic, a memory array, and the
// starvation/grant rules), checked with immediate assertions.
module tb_mem_arbiter;

  localparam int LIMIT = 2;
  localparam int TMO   = 15;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_ack;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_stall;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        err;
  logic [15:0] i_grant_cnt;
  logic [15:0] d_grant_cnt;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem_model [logic [15:0]];
  int          d_streak = 0;
  logic [15:0] i_cnt_exp = 0;
  logic [15:0] d_cnt_exp = 0;
  logic        err_exp = 0;
  int          txn_no = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'hA5C3;
  endfunction

  // D wins unless it is absent or I has already waited through LIMIT D grants.
  task automatic model_grant(input bit ip, input bit dp, output bit own_d);
    own_d = dp && !(ip && d_streak >= LIMIT);
    if (own_d && ip) d_streak++;
    else d_streak = 0;
    if (own_d) begin
      if (d_cnt_exp != 16'hFFFF) d_cnt_exp++;
    end else begin
      if (i_cnt_exp != 16'hFFFF) i_cnt_exp++;
    end
  endtask

  task automatic check_all_zero(input string where);
    chk({where, ".outs"}, {i_ack, i_done, d_ack, d_done, mem_en, mem_wr, busy, err}, 16'h0);
    chk({where, ".i_rdata"}, i_rdata, 16'h0);
    chk({where, ".d_rdata"}, d_rdata, 16'h0);
    chk({where, ".mem_addr"}, mem_addr, 16'h0);
    chk({where, ".mem_wdata"}, mem_wdata, 16'h0);
    chk({where, ".i_cnt"}, i_grant_cnt, 16'h0);
    chk({where, ".d_cnt"}, d_grant_cnt, 16'h0);
  endtask

  // One transaction: requests already driven, current time is in an IDLE cycle
  // (cycle 0). Walks cycles 1..done+1 checking the timeline and acting as backend.
  task automatic run_txn(input bit own_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int stall, input int lat,
                         input bit tmo, input bit drop);
    int          accept_c;
    int          rv_c;
    int          done_c;
    logic [15:0] exp_rd;
    accept_c = stall + 1;
    rv_c     = stall + 2 + lat;
    if (wr)       done_c = stall + 2;
    else if (tmo) done_c = stall + 2 + TMO;
    else          done_c = rv_c + 1;
    exp_rd = wr ? 16'h0 : (tmo ? 16'hFFFF : mem_read(addr));
    txn_no++;
    for (int c = 1; c <= done_c + 1; c++) begin
      tick();
      chk("mem_en", mem_en, c <= accept_c);
      if (c <= accept_c) begin
        chk("mem_wr", mem_wr, wr);
        chk("mem_addr", mem_addr, addr);
        if (wr) chk("mem_wdata", mem_wdata, wdata);
      end
      chk("i_ack", i_ack, (c == 1) && !own_d);
      chk("d_ack", d_ack, (c == 1) && own_d);
      chk("i_done", i_done, (c == done_c) && !own_d);
      chk("d_done", d_done, (c == done_c) && own_d);
      chk("busy", busy, c <= done_c);
      if (c == done_c) begin
        if (tmo) err_exp = 1'b1;
        if (own_d) chk("d_rdata", d_rdata, exp_rd);
        else       chk("i_rdata", i_rdata, exp_rd);
        chk("err", err, err_exp);
        chk("i_grant_cnt", i_grant_cnt, i_cnt_exp);
        chk("d_grant_cnt", d_grant_cnt, d_cnt_exp);
        $display("txn %0d: %s %s addr=%h rdata=%h stall=%0d lat=%0d tmo=%0d done@%0d",
                 txn_no, own_d ? "D" : "I", wr ? "WR" : "RD", addr,
                 own_d ? d_rdata : i_rdata, stall, lat, tmo, c);
      end
      // Drive inputs for cycle c.
      if (c == 1 && drop) begin
        if (own_d) d_req = 1'b0;
        else       i_req = 1'b0;
      end
      mem_stall  = (c <= stall);
      mem_rvalid = !wr && !tmo && (c == rv_c);
      mem_rdata  = (!wr && !tmo && (c == rv_c)) ? exp_rd : 16'h0;
    end
    if (wr) mem_model[addr] = wdata;
  endtask

  initial begin : main
    bit          own;
    bit          i_pend;
    bit          d_pend;
    int          st;
    int          lt;
    rst = 1'b0;
    i_req = 0; i_addr = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_stall = 0; mem_rvalid = 0; mem_rdata = 0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Single I read: data returned two cycles after mem_en, done in cycle 4.
    mem_model[16'h0040] = 16'h1234;
    i_req = 1; i_addr = 16'h0040;
    model_grant(1, 0, own);
    run_txn(own, 0, 16'h0040, 16'h0, 0, 1, 0, 1);

    // D write with three stalled cycles.
    d_req = 1; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    model_grant(0, 1, own);
    run_txn(own, 1, 16'h0100, 16'hBEEF, 3, 0, 0, 1);

    // Both requests held continuously: D, D, I, D, D, I.
    i_req = 1; i_addr = 16'h0300;
    d_req = 1; d_wr = 1; d_addr = 16'h0110; d_wdata = 16'h5A5A;
    for (int g = 0; g < 6; g++) begin
      model_grant(1, 1, own);
      run_txn(own, own ? 1'b1 : 1'b0, own ? 16'h0110 : 16'h0300,
              own ? 16'h5A5A : 16'h0, 0, 0, 0, 0);
    end
    i_req = 0; d_req = 0;
    tick();

    // Randomized mix, single or overlapping requests, no timeouts.
    i_pend = 0; d_pend = 0;
    for (int n = 0; n < 40; n++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1;
        i_addr = {12'h010, 4'($urandom_range(0, 15))};
      end
      if (!d_pend && ($urandom_range(0, 1) == 1 || !i_pend)) begin
        d_pend  = 1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = {12'h010, 4'($urandom_range(0, 15))};
        d_wdata = 16'($urandom);
      end
      i_req = i_pend; d_req = d_pend;
      model_grant(i_pend, d_pend, own);
      if (own) d_pend = 0;
      else     i_pend = 0;
      st = $urandom_range(0, 3);
      lt = $urandom_range(0, 4);
      run_txn(own, own ? d_wr : 1'b0, own ? d_addr : i_addr,
              own ? d_wdata : 16'h0, st, lt, 0, 1);
    end
    i_req = 0; d_req = 0;
    d_streak = 0;
    tick();

    // Stray read data while idle: err set, no done, data dropped.
    mem_rvalid = 1; mem_rdata = 16'h7777;
    tick();
    mem_rvalid = 0; mem_rdata = 0;
    err_exp = 1'b1;
    chk("stray.err", err, err_exp);
    for (int c = 0; c < 2; c++) begin
      chk("stray.dones", {i_done, d_done, busy}, 16'h0);
      tick();
    end

    // Reset in the middle of WAIT for an I read.
    i_req = 1; i_addr = 16'h0200;
    tick();
    chk("rst.i_ack", i_ack, 1'b1);
    i_req = 0;
    tick(); tick();
    chk("rst.busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("midwait");
    tick();
    rst = 1'b1;
    i_cnt_exp = 0; d_cnt_exp = 0; err_exp = 0; d_streak = 0;
    tick();
    check_all_zero("post_rst");

    // A new D read completes normally.
    d_req = 1; d_wr = 0; d_addr = 16'h0100;
    model_grant(0, 1, own);
    run_txn(own, 0, 16'h0100, 16'h0, 0, 2, 0, 1);

    // D read timeout: done in cycle 17 with 0xFFFF, err set.
    d_req = 1; d_wr = 0; d_addr = 16'h0444;
    model_grant(0, 1, own);
    run_txn(own, 0, 16'h0444, 16'h0, 0, 0, 1, 1);

    // err stays set through later good transactions.
    i_req = 1; i_addr = 16'h0040;
    model_grant(1, 0, own);
    run_txn(own, 0, 16'h0040, 16'h0, 1, 0, 0, 1);
    d_req = 1; d_wr = 1; d_addr = 16'h0120; d_wdata = 16'hC0DE;
    model_grant(0, 1, own);
    run_txn(own, 1, 16'h0120, 16'hC0DE, 0, 0, 0, 1);
    chk("err.sticky", err, err_exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
